// File: rtl/ca_sched.sv
// ca_sched -- generation scheduler for a double-buffered cellular-automaton row
// memory.
//
// The block counts video frames. Every GEN_DIV frames it starts one
// generation of the external generator. That generation reads the front
// (source) bank and writes the back (destination) bank. When the generator
// reports done, the banks swap. The display reads the front bank at any time
// and takes priority over the generator on the single memory read port.
//
// Parameters
//   GEN_DIV   : frame ticks per generation (1..255)
//   ROW_WORDS : 16-bit words per row; bank A base 0, bank B base ROW_WORDS
//   TIMEOUT   : max cycles from gen_start to gen_done before giving up
//
// Ports
//   clk, rst                 : clock (rising edge), synchronous active-high reset
//   enable, frame_tick       : generation enable, one-cycle pulse per frame
//   step (CA_SCHED_STEP_EN)  : single-step start request, honoured only in IDLE
//   gen_start / gen_done     : generator handshake pulses
//   gen_read/gen_raddr       : generator read request, row-relative address
//   gen_write/gen_waddr/
//   gen_wdata                : generator write, row-relative address
//   gen_rvalid, gen_stall    : generator read data valid / read not granted
//   disp_read/disp_raddr     : display read request, row-relative address
//   disp_rvalid              : display read data valid
//   mem_*                    : memory ports (read data returns one cycle later)
//   front_bank               : bank currently shown to the display
//   gen_count                : completed generations (wraps)
//   timeout_err              : sticky, set when a generation timed out
//
// Optional feature: define CA_SCHED_STEP_EN to add the step input.

module ca_sched #(
  parameter int GEN_DIV   = 4,
  parameter int ROW_WORDS = 80,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_tick,
`ifdef CA_SCHED_STEP_EN
  input  logic        step,
`endif
  output logic        gen_start,
  input  logic        gen_done,
  input  logic        gen_read,
  input  logic [7:0]  gen_raddr,
  input  logic        gen_write,
  input  logic [7:0]  gen_waddr,
  input  logic [15:0] gen_wdata,
  output logic        gen_rvalid,
  output logic        gen_stall,
  input  logic        disp_read,
  input  logic [7:0]  disp_raddr,
  output logic        disp_rvalid,
  output logic        mem_re,
  output logic [7:0]  mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_waddr,
  output logic [15:0] mem_wdata,
  output logic        front_bank,
  output logic [15:0] gen_count,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          front_q, front_d;
  logic [15:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          gen_start_q, gen_start_d;
  logic          gen_rvalid_q, gen_rvalid_d;
  logic          disp_rvalid_q, disp_rvalid_d;

  logic          step_go;
  logic [7:0]    div_nxt;
  logic [TW-1:0] tmo_nxt;
  logic          gen_active;
  logic          disp_grant, gen_grant;
  logic [7:0]    src_base, dst_base;

  // Read data travels straight from memory to the requesters; this block only
  // tracks when it is valid.
  logic          unused_rdata;
  assign unused_rdata = ^mem_rdata;

`ifdef CA_SCHED_STEP_EN
  assign step_go = step;
`else
  assign step_go = 1'b0;
`endif

  assign div_nxt    = div_q + 8'd1;
  assign tmo_nxt    = tmo_q + TW'(1);
  assign gen_active = (state_q == S_START) || (state_q == S_RUN);

  // Source bank is the front bank; the generator writes the other one.
  assign src_base = front_q ? 8'(ROW_WORDS) : 8'd0;
  assign dst_base = front_q ? 8'd0 : 8'(ROW_WORDS);

  // Display always wins the read port; generator reads only while a
  // generation is in flight.
  assign disp_grant = disp_read;
  assign gen_grant  = gen_read & ~disp_read & gen_active;
  assign gen_stall  = gen_read & disp_read;

  assign mem_re    = disp_grant | gen_grant;
  assign mem_raddr = (disp_read ? disp_raddr : gen_raddr) + src_base;
  assign mem_we    = gen_write & gen_active;
  assign mem_waddr = gen_waddr + dst_base;
  assign mem_wdata = gen_wdata;

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    tmo_d         = tmo_q;
    front_d       = front_q;
    count_d       = count_q;
    err_d         = err_q;
    gen_start_d   = 1'b0;
    gen_rvalid_d  = gen_grant;
    disp_rvalid_d = disp_grant;

    case (state_q)
      S_IDLE: begin
        // A step request bypasses enable and leaves the divider untouched.
        if (step_go) begin
          state_d     = S_START;
          gen_start_d = 1'b1;
        end else if (enable && frame_tick) begin
          if (div_nxt == 8'(GEN_DIV)) begin
            div_d       = 8'd0;
            state_d     = S_START;
            gen_start_d = 1'b1;
          end else begin
            div_d = div_nxt;
          end
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Completion wins over a timeout landing on the same cycle.
        if (gen_done) begin
          state_d = S_SWAP;
        end else if (tmo_nxt == TW'(TIMEOUT)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_nxt;
        end
      end
      S_SWAP: begin
        front_d = ~front_q;
        count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      div_q         <= 8'd0;
      tmo_q         <= '0;
      front_q       <= 1'b0;
      count_q       <= 16'd0;
      err_q         <= 1'b0;
      gen_start_q   <= 1'b0;
      gen_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      tmo_q         <= tmo_d;
      front_q       <= front_d;
      count_q       <= count_d;
      err_q         <= err_d;
      gen_start_q   <= gen_start_d;
      gen_rvalid_q  <= gen_rvalid_d;
      disp_rvalid_q <= disp_rvalid_d;
    end
  end

  assign gen_start   = gen_start_q;
  assign gen_rvalid  = gen_rvalid_q;
  assign disp_rvalid = disp_rvalid_q;
  assign front_bank  = front_q;
  assign gen_count   = count_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_ca_sched.sv
module tb_ca_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        frame_tick;
`ifdef CA_SCHED_STEP_EN
  logic        step;
`endif
  logic        gen_start;
  logic        gen_done;
  logic        gen_read;
  logic [7:0]  gen_raddr;
  logic        gen_write;
  logic [7:0]  gen_waddr;
  logic [15:0] gen_wdata;
  logic        gen_rvalid;
  logic        gen_stall;
  logic        disp_read;
  logic [7:0]  disp_raddr;
  logic        disp_rvalid;
  logic        mem_re;
  logic [7:0]  mem_raddr;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        front_bank;
  logic [15:0] gen_count;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ca_sched #(.GEN_DIV(4), .ROW_WORDS(80), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
`ifdef CA_SCHED_STEP_EN
    .step(step),
`endif
    .gen_start(gen_start), .gen_done(gen_done),
    .gen_read(gen_read), .gen_raddr(gen_raddr),
    .gen_write(gen_write), .gen_waddr(gen_waddr), .gen_wdata(gen_wdata),
    .gen_rvalid(gen_rvalid), .gen_stall(gen_stall),
    .disp_read(disp_read), .disp_raddr(disp_raddr), .disp_rvalid(disp_rvalid),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .front_bank(front_bank), .gen_count(gen_count), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        dr;
    logic [7:0]  dra;
    logic        gr;
    logic [7:0]  gra;
    logic        gw;
    logic [7:0]  gwa;
    logic [15:0] gwd;
    logic        e_re;
    logic [7:0]  e_ra;
    logic        e_stall;
    logic        e_we;
    logic [7:0]  e_wa;
    logic        e_drv;
    logic        e_grv;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic clear_ports();
    disp_read = 1'b0; disp_raddr = 8'd0;
    gen_read  = 1'b0; gen_raddr  = 8'd0;
    gen_write = 1'b0; gen_waddr  = 8'd0; gen_wdata = 16'd0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; gen_done = 1'b0;
    mem_rdata = 16'h5A5A;
`ifdef CA_SCHED_STEP_EN
    step = 1'b0;
`endif
    clear_ports();

    // Vectors applied during RUN with front_bank=0: src base 0, dst base 80.
    vecs[0] = '{1'b0, 8'd0,   1'b1, 8'd7,   1'b0, 8'd0,   16'h0000, 1'b1, 8'd7,   1'b0, 1'b0, 8'd0,  1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 8'd3,   16'hA5A5, 1'b0, 8'd0,   1'b0, 1'b1, 8'd83, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'd10,  1'b1, 8'd2,   1'b1, 8'd200, 16'h1234, 1'b1, 8'd10,  1'b1, 1'b1, 8'd24, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'd250, 1'b0, 8'd0,   1'b0, 8'd0,   16'h0000, 1'b1, 8'd250, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'd0,   1'b1, 8'd255, 1'b1, 8'd255, 16'hFFFF, 1'b1, 8'd255, 1'b0, 1'b1, 8'd79, 1'b0, 1'b1};

    tick(); tick();
    rst = 1'b0;
    chk("rst_front", front_bank, 0);
    chk("rst_count", gen_count, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_start", gen_start, 0);
    chk("rst_grv", gen_rvalid, 0);
    chk("rst_drv", disp_rvalid, 0);

    // IDLE: display read serviced, generator blocked.
    disp_read = 1'b1; disp_raddr = 8'd5; gen_read = 1'b1; gen_raddr = 8'd9;
    #1;
    chk("idle_re", mem_re, 1);
    chk("idle_raddr", mem_raddr, 5);
    chk("idle_stall", gen_stall, 1);
    tick();
    chk("idle_drv", disp_rvalid, 1);
    chk("idle_grv", gen_rvalid, 0);
    disp_read = 1'b0; gen_write = 1'b1; gen_waddr = 8'd4;
    #1;
    chk("idle_gen_re", mem_re, 0);
    chk("idle_gen_we", mem_we, 0);
    chk("idle_gen_stall", gen_stall, 0);
    tick();
    chk("idle_gen_grv", gen_rvalid, 0);
    clear_ports();

    // Divider: disabled tick must not count.
    enable = 1'b1;
    pulse_tick(); pulse_tick();
    enable = 1'b0; pulse_tick();
    enable = 1'b1; pulse_tick();
    chk("div_no_start3", gen_start, 0);
    pulse_tick();
    chk("div_start4", gen_start, 1);
    tick();
    chk("start_one_cycle", gen_start, 0);

    // RUN: table-driven port checks.
    for (int i = 0; i < 5; i++) begin
      disp_read = vecs[i].dr; disp_raddr = vecs[i].dra;
      gen_read  = vecs[i].gr; gen_raddr  = vecs[i].gra;
      gen_write = vecs[i].gw; gen_waddr  = vecs[i].gwa; gen_wdata = vecs[i].gwd;
      #1;
      chk($sformatf("v%0d_re", i), mem_re, vecs[i].e_re);
      chk($sformatf("v%0d_stall", i), gen_stall, vecs[i].e_stall);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
      if (vecs[i].e_re) chk($sformatf("v%0d_raddr", i), mem_raddr, vecs[i].e_ra);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), mem_waddr, vecs[i].e_wa);
        chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].gwd);
      end
      tick();
      chk($sformatf("v%0d_drv", i), disp_rvalid, vecs[i].e_drv);
      chk($sformatf("v%0d_grv", i), gen_rvalid, vecs[i].e_grv);
    end
    clear_ports();

    // Completion and swap.
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    chk("swap_front_early", front_bank, 0);
    chk("swap_count_early", gen_count, 0);
    tick();
    chk("swap_front", front_bank, 1);
    chk("swap_count", gen_count, 1);

    // Bank 1 is front: display read at 5 maps to 85.
    disp_read = 1'b1; disp_raddr = 8'd5; gen_read = 1'b1; gen_raddr = 8'd1;
    #1;
    chk("b1_raddr", mem_raddr, 85);
    chk("b1_stall", gen_stall, 1);
    tick();
    chk("b1_drv", disp_rvalid, 1);
    chk("b1_grv", gen_rvalid, 0);
    clear_ports();

    // Timeout after 16 RUN cycles; frame tick during RUN ignored.
    repeat (3) pulse_tick();
    pulse_tick();
    chk("t_start", gen_start, 1);
    tick();
    gen_write = 1'b1; gen_waddr = 8'd0;
    #1;
    chk("t_waddr", mem_waddr, 0);
    pulse_tick();
    repeat (14) tick();
    chk("t_run16_we", mem_we, 1);
    chk("t_run16_err", timeout_err, 0);
    tick();
    chk("t_idle_we", mem_we, 0);
    chk("t_err", timeout_err, 1);
    chk("t_front", front_bank, 1);
    chk("t_count", gen_count, 1);
    gen_write = 1'b0;

    // gen_done outside RUN ignored.
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    tick(); tick();
    chk("late_done_front", front_bank, 1);
    chk("late_done_count", gen_count, 1);
    chk("err_sticky", timeout_err, 1);

    // Divider was cleared at start and frozen through RUN.
    repeat (3) pulse_tick();
    chk("frz_no_start", gen_start, 0);
    pulse_tick();
    chk("frz_start", gen_start, 1);
    tick();

    // Reset mid-RUN abandons the generation.
    gen_write = 1'b1;
    #1;
    chk("r_run_we", mem_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_we_blocked", mem_we, 0);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    tick();
    chk("r_count", gen_count, 0);
    chk("r_front", front_bank, 0);
    chk("r_err", timeout_err, 0);
    chk("r_idle_we", mem_we, 0);
    gen_write = 1'b0;

`ifdef CA_SCHED_STEP_EN
    enable = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_start", gen_start, 1);
    tick();
    pulse_tick();
    chk("step_tick_ignored", gen_start, 0);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    tick();
    chk("step_front", front_bank, 1);
    chk("step_count", gen_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ca_sched.md
CA_SCHED -- requirements
Module: ca_sched

Interface
REQ-001 SHALL have parameter GEN_DIV, default 4: frame ticks per generation (1..255).
REQ-002 SHALL have parameter ROW_WORDS, default 80: 16-bit words per CA row; bank A base 0, bank B base ROW_WORDS.
REQ-003 SHALL have parameter TIMEOUT, default 1023: max cycles from gen_start to gen_done.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: enable  in  1  allow generations; frame_tick  in  1  one-cycle pulse per video frame.
REQ-006 SHALL have ports: gen_start  out  1  start pulse to generator; gen_done  in  1  generator finished pulse.
REQ-007 SHALL have ports: gen_read  in  1; gen_raddr  in  8  row-relative read address; gen_write  in  1; gen_waddr  in  8  row-relative write address; gen_wdata  in  16.
REQ-008 SHALL have ports: gen_rvalid  out  1  gen read data valid; gen_stall  out  1  gen read not granted this cycle.
REQ-009 SHALL have ports: disp_read  in  1; disp_raddr  in  8  row-relative; disp_rvalid  out  1.
REQ-010 SHALL have ports: mem_re  out  1; mem_raddr  out  8; mem_rdata  in  16  (1-cycle latency); mem_we  out  1; mem_waddr  out  8; mem_wdata  out  16.
REQ-011 SHALL have ports: front_bank  out  1  bank shown to display; gen_count  out  16  completed generations; timeout_err  out  1  sticky.

Function
REQ-012 SHALL implement FSM IDLE, START, RUN, SWAP.
REQ-013 IDLE: frame divider counts frame_tick while enable=1; on tick making count reach GEN_DIV, divider clears and FSM -> START.
REQ-014 frame_tick with enable=0 SHALL be ignored; divider holds its value.
REQ-015 START: gen_start=1 for exactly one cycle, timeout counter cleared, -> RUN.
REQ-016 RUN: gen_done=1 -> SWAP; timeout counter reaching TIMEOUT -> IDLE with timeout_err set, no bank swap, gen_count unchanged.
REQ-017 SWAP: front_bank toggles, gen_count increments (wraps 16'hFFFF -> 0), -> IDLE; one cycle.
REQ-018 frame_tick in START/RUN/SWAP SHALL be ignored (no queuing, divider frozen).
REQ-019 gen_done outside RUN SHALL be ignored.
REQ-020 Source bank = front_bank; destination bank = ~front_bank.
REQ-021 Read port physical address = relative address + base of bank (gen: source bank, disp: front_bank), 8-bit truncating add.
REQ-022 mem_we = gen_write only in START/RUN; mem_waddr = gen_waddr + destination base; mem_wdata = gen_wdata, combinational pass-through.
REQ-023 Read arbitration, fixed priority: disp_read granted whenever asserted; gen_read granted only if disp_read=0.
REQ-024 gen_stall = gen_read & disp_read, combinational, same cycle.
REQ-025 mem_re = granted request; disp_rvalid / gen_rvalid = registered grant, asserted the cycle after grant with mem_rdata valid.
REQ-026 gen_read/gen_write outside START/RUN SHALL be blocked (no mem access, no rvalid); display reads always serviced.
REQ-027 enable deasserted in RUN SHALL NOT abort the generation; it only suppresses further starts.

Reset
REQ-028 rst SHALL force FSM IDLE, divider 0, timeout counter 0, front_bank 0, gen_count 0, timeout_err 0, gen_start 0, gen_rvalid 0, disp_rvalid 0.
REQ-029 rst mid-RUN SHALL abandon the generation immediately: no swap, no count, writes blocked from the next cycle.
REQ-030 timeout_err SHALL clear only on rst.

Configuration
REQ-031 Macro CA_SCHED_STEP_EN SHALL add input step (1 bit): when defined, a step pulse in IDLE SHALL go to START regardless of enable and divider, divider unchanged; step in other states ignored.
REQ-032 Without CA_SCHED_STEP_EN the step port SHALL not exist and only the divider path starts generations.

Verification
REQ-033 GEN_DIV=4, enable=1, 4 frame_ticks -> one gen_start pulse 1 cycle after 4th tick; gen_done -> front_bank 0->1, gen_count=1 two cycles after gen_done.
REQ-034 disp_read+gen_read same cycle, disp_raddr=5, front_bank=1 -> mem_raddr=85, gen_stall=1, disp_rvalid=1 next cycle, gen_rvalid=0.
REQ-035 front_bank=0, gen_write=1, gen_waddr=3, gen_wdata=16'hA5A5 in RUN -> mem_we=1, mem_waddr=83, mem_wdata=16'hA5A5.
REQ-036 TIMEOUT=16, no gen_done -> IDLE after 16 RUN cycles, timeout_err=1, front_bank and gen_count unchanged.
REQ-037 rst in RUN, then gen_done -> gen_count=0, front_bank=0, FSM IDLE, no swap.
REQ-038 With CA_SCHED_STEP_EN, enable=0, step pulse in IDLE -> gen_start next cycle; frame_tick during RUN ignored.
